xmpl_flt_arb: RTL

Round-robin scheduler that shares one `xmpl_flt` filter instance between `NUM_REQ` requesters in the DSP core. It accepts operand pairs over valid/ready handshakes and drives the filter's enable and operand inputs. It then waits for the filter's status pulse and returns the 23-bit result, tagged with the requester index, over a valid/ready response port. An optional watchdog aborts operations that never complete.

---
 rtl/xmpl_flt_arb.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/xmpl_flt_arb.sv
// xmpl_flt_arb: round-robin scheduler sharing one xmpl_flt filter between
// NUM_REQ requesters. One operation is in flight at a time; the result comes
// back tagged with the owning requester's index.
// Optional watchdog: define XMPL_FLT_ARB_WATCHDOG_EN to abort WAIT after
// TIMEOUT_CYC status-less cycles (response flagged with rsp_err_o = 1).
module xmpl_flt_arb #(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    input  logic [NUM_REQ*7-1:0] req_a7_i,
    input  logic [NUM_REQ*8-1:0] req_b8_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [ID_W-1:0]      rsp_id_o,
    output logic [22:0]          rsp_c23_o,
    output logic                 rsp_err_o,
    output logic                 en_flt_o,
    output logic [6:0]           flt_a7_o,
    output logic [7:0]           flt_b8_o,
    input  logic [22:0]          flt_c23_i,
    input  logic                 flt_status_i,
    output logic                 busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] last_grant, grant_id, cap_id;
    logic            grant_vld, accept, timeout;
    logic [6:0]      sel_a, cap_a;
    logic [7:0]      sel_b, cap_b;
    logic [22:0]     rsp_c23;
    logic            rsp_err;

    // Out-of-range configurations elaborate an empty, clearly named block.
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255 || NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_cfg
    end

    // Requester index `off` positions after `base`, wrapping at NUM_REQ.
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
        return ID_W'((int'(base) + off) % NUM_REQ);
    endfunction

    // Round-robin search: scan from farthest to nearest so the nearest
    // requester after last_grant is the one left in grant_id.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (req_valid_i[wrap_idx(last_grant, i)]) begin
                grant_vld = 1'b1;
                grant_id  = wrap_idx(last_grant, i);
            end
        end
    end

    // Operand mux for the winning requester (constant slice bases only).
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_id == ID_W'(k)) begin
                sel_a = req_a7_i[7*k +: 7];
                sel_b = req_b8_i[8*k +: 8];
            end
        end
    end

    assign accept = (state == S_IDLE) && grant_vld;

    // One-hot ready to the winner; forced low while reset is asserted.
    always_comb begin
        req_ready_o = '0;
        if (accept && reset_n_i) begin
            req_ready_o[grant_id] = 1'b1;
        end
    end

`ifdef XMPL_FLT_ARB_WATCHDOG_EN
    logic [7:0] wd_cnt;

    // Watchdog counter: cleared in ISSUE, counts status-less WAIT cycles.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wd_cnt <= '0;
        end else if (state == S_ISSUE) begin
            wd_cnt <= '0;
        end else if (state == S_WAIT && !flt_status_i && !timeout) begin
            wd_cnt <= wd_cnt + 8'd1;
        end
    end

    // Abort at the end of WAIT cycle number TIMEOUT_CYC; status has priority.
    assign timeout = (state == S_WAIT) && !flt_status_i && (wd_cnt == 8'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (!reset_n_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (flt_status_i || timeout) state_nxt = S_RESP;
            S_RESP:  if (rsp_ready_i) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand capture, result capture, round-robin pointer.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        // NOTE: these data registers are reset because they drive outputs that must read 0 after reset.
        if (!reset_n_i) begin
            cap_a      <= '0;
            cap_b      <= '0;
            cap_id     <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
            rsp_c23    <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                cap_a  <= sel_a;
                cap_b  <= sel_b;
                cap_id <= grant_id;
            end
            if (state == S_WAIT) begin
                if (flt_status_i) begin
                    rsp_c23 <= flt_c23_i;
                    rsp_err <= 1'b0;
                end else if (timeout) begin
                    rsp_c23 <= '0;
                    rsp_err <= 1'b1;
                end
            end
            if (state == S_RESP && rsp_ready_i) begin
                last_grant <= cap_id;
            end
        end
    end

    assign en_flt_o    = (state == S_ISSUE);
    assign busy_o      = (state != S_IDLE);
    assign rsp_valid_o = (state == S_RESP);
    assign rsp_id_o    = cap_id;
    assign rsp_c23_o   = rsp_c23;
    assign rsp_err_o   = rsp_err;
    assign flt_a7_o    = cap_a;
    assign flt_b8_o    = cap_b;

endmodule
